// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: shared definitions for the sequencer controller.
//   opcode_t   - instruction opcodes held in the instruction register
//   state_t    - controller state encoding (also exported on state_o)
//   addr_sel_t - memory address source select
//   alu_op_t   - ALU operation select
//   op_class_t - opcode class flags produced by seq_ctrl_dec
package seq_ctrl_pkg;

  typedef enum logic [5:0] {
    OP_NOP  = 6'h00,
    OP_LDA  = 6'h01,
    OP_STA  = 6'h02,
    OP_ADDI = 6'h03,
    OP_SUBI = 6'h04,
    OP_BRA  = 6'h05,
    OP_BRZ  = 6'h06,
    OP_PUSH = 6'h07,
    OP_POP  = 6'h08,
    OP_HLT  = 6'h3F
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ADDR_PC = 2'd0,
    ADDR_BA = 2'd1,
    ADDR_SP = 2'd2
  } addr_sel_t;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_SUB  = 2'd2
  } alu_op_t;

  typedef struct packed {
    logic single;   // NOP, ADDI, SUBI
    logic mem;      // LDA, STA, PUSH, POP
    logic branch;   // BRA, BRZ
    logic halt;     // HLT
    logic illegal;  // anything else
  } op_class_t;

  localparam int unsigned WAIT_W   = 8;
  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

endpackage

// File: rtl/seq_ctrl_dec.sv
// seq_ctrl_dec: combinational opcode classifier.
//   opcode   in  6  instruction register opcode field
//   op_class out    one-hot class (single / mem / branch / halt / illegal)
module seq_ctrl_dec
  import seq_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  op_class
);

  always_comb begin
    op_class = '0;
    case (opcode)
      OP_NOP, OP_ADDI, OP_SUBI:         op_class.single  = 1'b1;
      OP_LDA, OP_STA, OP_PUSH, OP_POP:  op_class.mem     = 1'b1;
      OP_BRA, OP_BRZ:                   op_class.branch  = 1'b1;
      OP_HLT:                           op_class.halt    = 1'b1;
      default:                          op_class.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle instruction sequencer (IDLE/FETCH/DECODE/EXEC/MEM/HALT).
//   clk, rst          clock, asynchronous active-low reset
//   start             leave IDLE
//   opcode, ra        instruction register fields
//   flag_z            ALU zero flag (BRZ condition)
//   mem_ready         memory acknowledge
//   ir_w, pc_inc, pc_load, mem_req, mem_we, addr_sel, acc_w, alu_op,
//   sp_inc, sp_dec    datapath controls, decoded from state/opcode/mem_ready
//   halted, illegal, bus_err   status (illegal and bus_err are sticky)
//   state_o           current state for debug
module seq_ctrl
  import seq_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] opcode,
  input  logic       ra,
  input  logic       flag_z,
  input  logic       mem_ready,
  output logic       ir_w,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mem_req,
  output logic       mem_we,
  output logic [1:0] addr_sel,
  output logic [1:0] acc_w,
  output logic [1:0] alu_op,
  output logic       sp_inc,
  output logic       sp_dec,
  output logic       halted,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state_o
);

  state_t              state;
  logic [WAIT_W-1:0]   wait_cnt;
  op_class_t           cls;
  logic [1:0]          acc_sel;

  seq_ctrl_dec u_dec (
    .opcode   (opcode),
    .op_class (cls)
  );

  assign acc_sel = ra ? 2'b10 : 2'b01;

  // State, wait counter and sticky flags. The counter is cleared on every
  // transition into FETCH or MEM; a ready in the final count cycle completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
          end
        end
        S_FETCH: begin
          if (mem_ready) begin
            state <= S_DECODE;
          end else if (wait_cnt == WAIT_MAX) begin
            bus_err <= 1'b1;
            state   <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          wait_cnt <= '0;
          if (cls.halt) begin
            state <= S_HALT;
          end else if (cls.mem) begin
            state <= S_MEM;
          end else begin
            state <= S_FETCH;
            if (cls.illegal) illegal <= 1'b1;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_MAX) begin
            bus_err <= 1'b1;
            state   <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign state_o = state;
  assign halted  = (state == S_HALT);

  always_comb begin
    ir_w     = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = ADDR_PC;
    acc_w    = '0;
    alu_op   = ALU_PASS;
    sp_inc   = 1'b0;
    sp_dec   = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_w   = 1'b1;
          pc_inc = 1'b1;
        end
      end
      S_EXEC: begin
        if (cls.single) begin
          if (opcode == OP_ADDI) begin
            acc_w  = acc_sel;
            alu_op = ALU_ADD;
          end else if (opcode == OP_SUBI) begin
            acc_w  = acc_sel;
            alu_op = ALU_SUB;
          end
        end
        if (cls.branch) pc_load = (opcode == OP_BRA) | flag_z;
        if (opcode == OP_PUSH) sp_dec = 1'b1;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = (opcode == OP_LDA || opcode == OP_STA) ? ADDR_BA : ADDR_SP;
        mem_we   = (opcode == OP_STA || opcode == OP_PUSH);
        if (mem_ready) begin
          if (opcode == OP_LDA || opcode == OP_POP) acc_w = acc_sel;
          if (opcode == OP_POP) sp_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/seq_ctrl.md
SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 clk  in  1  rising-edge system clock.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 start  in  1  begin execution from IDLE.
REQ-004 opcode  in  6  opcode field held by the instruction register.
REQ-005 ra  in  1  accumulator select from the instruction register (0 = X, 1 = Y).
REQ-006 flag_z  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  memory handshake acknowledge.
REQ-008 ir_w  out  1  instruction register write enable.
REQ-009 pc_inc, pc_load  out  1 each  program counter increment and program counter load of BA.
REQ-010 mem_req, mem_we  out  1 each  memory request and write qualifier.
REQ-011 addr_sel  out  2  address source: 0 = PC, 1 = BA, 2 = SP.
REQ-012 acc_w  out  2  one-hot accumulator write (bit0 = X, bit1 = Y).
REQ-013 alu_op  out  2  ALU operation: 0 = pass, 1 = add IMM, 2 = sub IMM.
REQ-014 sp_inc, sp_dec  out  1 each  stack pointer adjust.
REQ-015 halted, illegal, bus_err  out  1 each  status flags.
REQ-016 state_o  out  3  current state encoding, for debug.

Function
REQ-017 Opcodes SHALL be: NOP=00h, LDA=01h, STA=02h, ADDI=03h, SUBI=04h, BRA=05h, BRZ=06h, PUSH=07h, POP=08h, HLT=3Fh; any other opcode is illegal.
REQ-018 States SHALL be: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, HALT=5; state is registered, and all outputs are decoded combinationally from the state, the opcode and mem_ready.
REQ-019 IDLE: all outputs are 0; start=1 moves to FETCH on the next edge.
REQ-020 FETCH: mem_req=1, addr_sel=0, mem_we=0; in the cycle where mem_ready=1, assert ir_w=1 and pc_inc=1 for exactly that cycle, then move to DECODE.
REQ-021 DECODE: no outputs asserted; exactly one cycle, so the IR contents are stable; then move to EXEC.
REQ-022 EXEC, ADDI/SUBI: assert acc_w[ra]=1 with alu_op=1/2, then move to FETCH.
REQ-023 EXEC, NOP: move to FETCH with no outputs asserted.
REQ-024 EXEC, BRA: assert pc_load=1, then move to FETCH.
REQ-025 EXEC, BRZ: assert pc_load=flag_z, then move to FETCH.
REQ-026 EXEC, HLT: move to HALT.
REQ-027 EXEC, PUSH: assert sp_dec=1, then move to MEM.
REQ-028 EXEC, LDA/STA/POP: move to MEM with no outputs asserted.
REQ-029 EXEC, illegal opcode: set the sticky illegal flag and behave as NOP.
REQ-030 MEM: mem_req=1; addr_sel=1 for LDA/STA and 2 for PUSH/POP; mem_we=1 for STA/PUSH.
REQ-031 MEM, completion: on mem_ready=1, assert acc_w[ra]=1 with alu_op=0 for LDA/POP, and sp_inc=1 for POP, then move to FETCH.
REQ-032 Wait counter: an 8-bit counter clears on entry to FETCH or MEM and increments each cycle mem_ready=0 in those states.
REQ-033 Timeout: when the counter reaches 255 with mem_ready=0, set the sticky bus_err flag and move to HALT; mem_ready=1 in that same cycle wins and completes normally.
REQ-034 HALT: halted=1 and all other control outputs are 0; the block stays in HALT until reset, and start is ignored.
REQ-035 mem_ready in IDLE, DECODE, EXEC or HALT SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-036 Minimum instruction latency SHALL be: 4 cycles for single-cycle ops with zero-wait memory (FETCH, DECODE, EXEC, back to FETCH); 5 cycles for memory ops.

Reset
REQ-037 rst=0 SHALL asynchronously force state=IDLE, wait counter=0, and illegal, bus_err and halted to 0; all outputs read 0 while rst=0.
REQ-038 Reset mid-handshake SHALL drop mem_req immediately; the first cycle after release is IDLE.

Structure
REQ-039 Package seq_ctrl_pkg SHALL hold the opcode constants, the state encoding, and the addr_sel and alu_op encodings.
REQ-040 The opcode classifier (single-cycle / memory / branch / halt / illegal) SHALL be a combinational sub-module seq_ctrl_dec; the FSM and wait counter stay in seq_ctrl.

Verification
REQ-041 Scenario, ADDI with zero-wait memory: reset, start=1, memory returns opcode 03h with ra=1 and mem_ready=1 -> ir_w and pc_inc pulse in cycle 1, acc_w=2'b10 with alu_op=1 in cycle 3, FETCH again in cycle 4.
REQ-042 Scenario, LDA with 3 wait states: LDA with mem_ready low for 3 MEM cycles -> mem_req and addr_sel=1 held 4 cycles, acc_w[ra] pulses only in the ready cycle.
REQ-043 Scenario, PUSH then POP: sp_dec in EXEC with mem_we=1 and addr_sel=2 in MEM; POP gives sp_inc together with acc_w in the ready cycle.
REQ-044 Scenario, BRZ: with flag_z=0 -> pc_load=0; with flag_z=1 -> pc_load=1; BRA always gives pc_load=1.
REQ-045 Scenario, illegal opcode and HLT: opcode 2Ah -> illegal=1 and execution continues; opcode 3Fh -> halted=1, and start=1 thereafter gives no change.
REQ-046 Scenario, timeout and reset: mem_ready held 0 in FETCH -> bus_err=1 and HALT after 256 cycles; rst=0 mid-MEM -> mem_req drops the same cycle and state_o=0.
